lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the 16-bit Fibonacci LFSR pattern generator (polynomial x^16+x^14+x^13+x^11+1, feedback = r[15]^r[13]^r[12]^r[10], shift left with feedback into bit 0). The block consumes the generator's 16-bit state word once per enabled beat and self-synchronises by seeding its predictor from the received stream. Once locked, it free-runs its own prediction and flags every mismatching word. It sits at the far end of a link or buffer under test and reports lock status and error counts for BIST and link qualification.

## Interface
- LOCK_COUNT, 4: consecutive matching beats required to enter LOCKED (1..15).
- LOSS_COUNT, 3: consecutive mismatching beats in LOCKED that force a return to SEARCH (1..15).
- CNT_W, 16: width of `err_count` and `word_count`.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  a received word is present this cycle (beat).
- data_in  input  16  received LFSR state word; sampled only when `enable`=1.
- clear_counts  input  1  synchronous clear of `err_count` and `word_count`; lock state unaffected.
- locked  output  1  checker in LOCKED state.
- error  output  1  one-cycle pulse: previous beat mismatched while LOCKED.
- err_count  output  CNT_W  saturating count of mismatched beats while LOCKED.
- word_count  output  CNT_W  saturating count of beats checked while LOCKED.

## Operation
- Definitions:
  - `next(x)` = {x[14:0], x[15]^x[13]^x[12]^x[10]}.
  - `match` = (data_in == next(pred)) && (data_in != 16'h0000). An all-zero word never matches.
- Registers: `pred[15:0]`, `have_prev`, `run_cnt[3:0]`, `miss_cnt[3:0]`, state.
- States:
  - SEARCH, on beat:
    - `pred <= data_in`; `have_prev <= 1`.
    - If `have_prev && match`, then `run_cnt++`; otherwise `run_cnt <= 0`.
    - When the increment makes `run_cnt` equal LOCK_COUNT: go to LOCKED, set `miss_cnt <= 0`.
  - LOCKED, on beat:
    - `pred <= next(pred)`. Prediction free-runs and is never reloaded from `data_in`, so a single corrupt word yields exactly one error.
    - Always: `word_count++` (saturating).
    - On match: `miss_cnt <= 0`.
    - On mismatch: `error` pulse, `err_count++` (saturating), `miss_cnt++`.
    - When `miss_cnt` reaches LOSS_COUNT: go to SEARCH, `pred <= data_in`, `run_cnt <= 0`, `have_prev <= 1`.
- With no beat (`enable`=0): state and registers hold; `error` = 0.
- Counters:
  - Saturate at all-ones; they never wrap.
  - `clear_counts` has priority over an increment in the same cycle, so the result is 0.
- Reset values:
  - State SEARCH; `pred` = 0; `have_prev` = 0; `run_cnt` = 0; `miss_cnt` = 0.
  - `locked` = 0, `error` = 0, `err_count` = 0, `word_count` = 0.
  - `rst` mid-operation discards lock immediately on the next edge.

## Timing
- All outputs are registered. Zero combinational path from inputs to outputs.
- `error` is high for exactly the cycle after the mismatching beat's edge.
- `locked` rises on the edge that samples the LOCK_COUNT-th consecutive matching beat. From reset, that is LOCK_COUNT+1 beats, because the first beat only seeds.
- `locked` falls on the edge that samples the LOSS_COUNT-th consecutive mismatch. That beat also raises `error` and counts in `err_count`.
- Back-to-back beats are accepted every cycle. Gaps in `enable` of any length are transparent.

## Structure
- Shared package `lfsr_pkg`:
  - `LFSR_W`=16.
  - Tap constants.
  - Function `lfsr_next()`, also used by the generator so both ends share one polynomial definition.
  - Checker state enum {SEARCH, LOCKED}.
- One natural sub-module: `lfsr_sat_counter`, a CNT_W saturating counter with clear and increment, instantiated twice (`err_count`, `word_count`).

## Test plan
- Reset: hold `rst` 2 cycles with random `data_in` and `enable`=1 → `locked`=0, `error`=0, both counts 0.
- Lock: beats 0x0001, 0x0002, 0x0004, 0x0008, 0x0010 (LOCK_COUNT=4) → `locked`=1 after the 5th beat's edge; counts 0.
- Single error: after lock, stream through 0x0200, send 0x0401 instead of 0x0400, then 0x0801 → one `error` pulse; `err_count`=1; `locked` stays 1; 0x0801 matches.
- Loss: while locked, send 3 consecutive zero words → `error` on each, `err_count`=3, `locked` falls with the third; a correct stream afterwards relocks after 5 beats.
- Gaps and clear: lock, insert random `enable`=0 gaps → no errors. Assert `clear_counts` in the same cycle as a mismatch beat → `err_count`=0, `error` still pulses.
- Saturation/zero: CNT_W=4, force 20 spaced single errors (`miss_cnt` resets between them) → `err_count`=15 holds. An all-zero stream from reset never locks.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator/checker pair.
// Polynomial x^16+x^14+x^13+x^11+1 with taps at bits 15, 13, 12 and 10.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Generator and checker both call this, so the two ends share one polynomial.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Beat-level interface between a received LFSR stream source and lfsr_checker.
// The master drives the beats; the slave (the checker) reports lock and errors.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  import lfsr_pkg::*;

  logic              enable;
  logic [LFSR_W-1:0] data_in;
  logic              clear_counts;
  logic              locked;
  logic              error;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output enable, data_in, clear_counts,
    input  locked, error, err_count, word_count
  );

  modport slave (
    input  enable, data_in, clear_counts,
    output locked, error, err_count, word_count
  );

endinterface

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the 16-bit LFSR pattern generator:
// seeds from the stream in SEARCH, free-runs its prediction once LOCKED.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave bus
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  chk_state_e        r_state;
  logic [LFSR_W-1:0] r_pred;
  logic              r_have_prev;
  logic [3:0]        r_run_cnt;
  logic [3:0]        r_miss_cnt;
  logic              r_error;

  chk_state_e        w_state_nxt;
  logic [LFSR_W-1:0] w_pred_nxt;
  logic              w_have_prev_nxt;
  logic [3:0]        w_run_nxt;
  logic [3:0]        w_miss_nxt;
  logic              w_error_nxt;
  logic              w_err_inc;
  logic              w_word_inc;

  logic [LFSR_W-1:0] w_expect;
  logic              w_match;
  logic [3:0]        w_run_inc;
  logic [3:0]        w_miss_inc;
  logic [CNT_W-1:0]  w_err_count;
  logic [CNT_W-1:0]  w_word_count;

  assign w_expect   = lfsr_next(r_pred);
  assign w_match    = (bus.data_in == w_expect) && (bus.data_in != '0);
  assign w_run_inc  = r_run_cnt + 4'd1;
  assign w_miss_inc = r_miss_cnt + 4'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pred_nxt      = r_pred;
    w_have_prev_nxt = r_have_prev;
    w_run_nxt       = r_run_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_error_nxt     = 1'b0;
    w_err_inc       = 1'b0;
    w_word_inc      = 1'b0;

    if (bus.enable) begin
      case (r_state)
        SEARCH: begin
          w_pred_nxt      = bus.data_in;
          w_have_prev_nxt = 1'b1;
          if (r_have_prev && w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == LOCK_C) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = 4'd0;
            end
          end else begin
            w_run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // Never reloaded from the stream, so one corrupt word costs exactly one error.
          w_pred_nxt = w_expect;
          w_word_inc = 1'b1;
          if (w_match) begin
            w_miss_nxt = 4'd0;
          end else begin
            w_error_nxt = 1'b1;
            w_err_inc   = 1'b1;
            w_miss_nxt  = w_miss_inc;
            if (w_miss_inc == LOSS_C) begin
              w_state_nxt     = SEARCH;
              w_pred_nxt      = bus.data_in;
              w_run_nxt       = 4'd0;
              w_have_prev_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred      <= '0;
      r_have_prev <= 1'b0;
      r_run_cnt   <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_error     <= 1'b0;
    end else begin
      r_pred      <= w_pred_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_run_cnt   <= w_run_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_error     <= w_error_nxt;
    end
  end

  lfsr_sat_counter #(.W(CNT_W)) u_err_count (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear_counts),
    .i_inc   (w_err_inc),
    .o_count (w_err_count)
  );

  lfsr_sat_counter #(.W(CNT_W)) u_word_count (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear_counts),
    .i_inc   (w_word_inc),
    .o_count (w_word_count)
  );

  assign bus.locked     = (r_state == LOCKED);
  assign bus.error      = r_error;
  assign bus.err_count  = w_err_count;
  assign bus.word_count = w_word_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: two instances (CNT_W=16 and CNT_W=4) share
// one stimulus stream and are compared against a behavioural model every cycle.
module tb_lfsr_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear_counts = 1'b0;
  logic [15:0] data_in = 16'h0000;

  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) bus16 ();
  lfsr_checker_if #(.CNT_W(4))  bus4 ();

  assign bus16.enable       = enable;
  assign bus16.data_in      = data_in;
  assign bus16.clear_counts = clear_counts;
  assign bus4.enable        = enable;
  assign bus4.data_in       = data_in;
  assign bus4.clear_counts  = clear_counts;

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          edge_no;
    logic        locked;
    logic        error;
    logic [15:0] ec16;
    logic [15:0] wc16;
    logic [3:0]  ec4;
    logic [3:0]  wc4;
  } exp_t;

  exp_t        sb_q[$];
  bit          m_locked = 1'b0;
  logic [15:0] m_pred = 16'h0000;
  int          m_miss = 0;
  int          m_ec = 0;
  int          m_wc = 0;
  logic [15:0] hist[$];

  // Next LFSR word: shift left, feed back the parity of the tapped bits (mask 0xB400).
  function automatic logic [15:0] ref_next(input logic [15:0] x);
    logic [15:0] sh;
    sh = x << 1;
    return sh | 16'(^(x & 16'hB400));
  endfunction

  // Lock when the newest LOCK_COUNT+1 received words form an unbroken nonzero chain.
  function automatic bit chain_ok();
    int n;
    n = hist.size();
    if (n < LOCK_COUNT + 1) return 1'b0;
    for (int i = n - LOCK_COUNT; i < n; i++) begin
      if (hist[i] == 16'h0000 || hist[i] != ref_next(hist[i-1])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic model_step(input bit r, input bit en, input logic [15:0] d,
                            input bit clr, output bit e_err);
    logic [15:0] want;
    e_err = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_pred   = 16'h0000;
      m_miss   = 0;
      m_ec     = 0;
      m_wc     = 0;
      hist.delete();
      return;
    end
    if (en) begin
      if (!m_locked) begin
        hist.push_back(d);
        if (hist.size() > 32) void'(hist.pop_front());
        if (chain_ok()) begin
          m_locked = 1'b1;
          m_pred   = d;
          m_miss   = 0;
          hist.delete();
        end
      end else begin
        want   = ref_next(m_pred);
        m_pred = want;
        m_wc++;
        if (d == want && d != 16'h0000) begin
          m_miss = 0;
        end else begin
          e_err = 1'b1;
          m_ec++;
          m_miss++;
          if (m_miss == LOSS_COUNT) begin
            m_locked = 1'b0;
            hist.delete();
            hist.push_back(d);
          end
        end
      end
    end
    if (clr) begin
      m_ec = 0;
      m_wc = 0;
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, step past the edge.
  task automatic drive(input bit r, input bit en, input logic [15:0] d, input bit clr);
    exp_t e;
    bit   er;
    rst          = r;
    enable       = en;
    data_in      = d;
    clear_counts = clr;
    model_step(r, en, d, clr, er);
    e.edge_no = edge_cnt + 1;
    e.locked  = m_locked;
    e.error   = er;
    e.ec16    = sat16(m_ec);
    e.wc16    = sat16(m_wc);
    e.ec4     = sat4(m_ec);
    e.wc4     = sat4(m_wc);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].edge_no < edge_cnt) begin
      total++;
      bad++;
      $display("FAIL sb_stale at t=%0t: got edge %0d want edge %0d", $time, edge_cnt, sb_q[0].edge_no);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].edge_no == edge_cnt) begin
      e = sb_q.pop_front();
      check("locked16", bus16.locked,     e.locked);
      check("error16",  bus16.error,      e.error);
      check("errcnt16", bus16.err_count,  e.ec16);
      check("wrdcnt16", bus16.word_count, e.wc16);
      check("locked4",  bus4.locked,      e.locked);
      check("error4",   bus4.error,       e.error);
      check("errcnt4",  bus4.err_count,   e.ec4);
      check("wrdcnt4",  bus4.word_count,  e.wc4);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] gen;

  initial begin
    bit          r, en, clr;
    int          k;
    logic [15:0] d;

    @(posedge clk);
    #1;

    repeat (2) drive(1'b1, 1'b1, 16'($urandom), 1'b0);
    check("reset_locked", bus16.locked, 0);
    check("reset_error",  bus16.error, 0);
    check("reset_errcnt", bus16.err_count, 0);
    check("reset_wrdcnt", bus16.word_count, 0);

    gen = 16'h0001;
    send(gen);
    repeat (LOCK_COUNT - 1) begin gen = ref_next(gen); send(gen); end
    check("lock_early", bus16.locked, 0);
    gen = ref_next(gen);
    send(gen);
    check("lock_fifth", bus16.locked, 1);
    check("lock_errcnt", bus16.err_count, 0);

    while (gen != 16'h0200) begin gen = ref_next(gen); send(gen); end
    gen = ref_next(gen);
    send(gen | 16'h0001);
    check("single_err_pulse", bus16.error, 1);
    gen = ref_next(gen);
    send(gen);
    check("single_err_follow", data_in, 16'h0801);
    check("single_err_clear", bus16.error, 0);
    check("single_err_count", bus16.err_count, 1);
    check("single_err_locked", bus16.locked, 1);

    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("clear_idle", bus16.err_count, 0);

    repeat (LOSS_COUNT - 1) begin gen = ref_next(gen); send(16'h0000); end
    check("loss_still_locked", bus16.locked, 1);
    gen = ref_next(gen);
    send(16'h0000);
    check("loss_unlocked", bus16.locked, 0);
    check("loss_errcnt", bus16.err_count, 3);

    repeat (LOCK_COUNT) begin gen = ref_next(gen); send(gen); end
    check("relock_early", bus16.locked, 0);
    gen = ref_next(gen);
    send(gen);
    check("relock", bus16.locked, 1);

    repeat (40) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, 16'($urandom), 1'b0);
      else begin gen = ref_next(gen); send(gen); end
    end
    check("gaps_errcnt", bus16.err_count, 3);

    gen = ref_next(gen);
    drive(1'b0, 1'b1, gen ^ 16'h0010, 1'b1);
    check("clr_mismatch_pulse", bus16.error, 1);
    check("clr_mismatch_count", bus16.err_count, 0);

    repeat (20) begin
      gen = ref_next(gen);
      send(gen ^ 16'h0100);
      repeat (2) begin gen = ref_next(gen); send(gen); end
    end
    check("sat4_errcnt", bus4.err_count, 15);
    check("sat16_errcnt", bus16.err_count, 20);

    repeat (600) begin
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      d   = 16'($urandom);
      if (en) begin
        k   = $urandom_range(0, 31);
        gen = ref_next(gen);
        if (k == 0)      d = 16'h0000;
        else if (k == 1) d = gen ^ 16'($urandom_range(1, 65535));
        else if (k == 2) begin gen = 16'($urandom_range(1, 65535)); d = gen; end
        else             d = gen;
      end
      drive(r, en, d, clr);
    end

    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    repeat (30) send(16'h0000);
    check("zero_never_locks", bus16.locked, 0);

    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
